counter_reader: RTL

COUNTER_READER -- requirements
Module: counter_reader

---
 rtl/counter_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/counter_reader.sv
// counter_reader: runs LOAD/READ commands against a shared counter bus; rsp_delta only with COUNTER_READER_DELTA_EN.
// Latency: LOAD pulses the cycle after acceptance; READ result is valid TURN_CYCLES edges after acceptance.
// Backpressure: req_ready only in IDLE; the response holds until rsp_ready, then one turnaround cycle.
module counter_reader #(
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_data,
  output logic       cnt_load_e,
  output logic [7:0] cnt_load_val,
  output logic       cnt_out_e,
  input  logic [7:0] cnt_bus,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_delta
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENABLE,
    RESP,
    TURN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] en_cnt_q;
  logic [7:0] load_val_q;
  logic [7:0] rsp_data_q;
  logic       accept;
  logic       sample;

  assign accept = req_valid && (state_q == IDLE);
  // The bus is captured on the edge that closes the final enable cycle.
  assign sample = (state_q == ENABLE) && (en_cnt_q == 4'(TURN_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      en_cnt_q   <= 4'd0;
      load_val_q <= 8'h00;
      rsp_data_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      en_cnt_q <= (state_q == ENABLE) ? en_cnt_q + 4'd1 : 4'd0;
      if (accept && req_op) begin
        load_val_q <= req_data;
      end
      if (sample) begin
        rsp_data_q <= cnt_bus;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    cnt_load_e   = 1'b0;
    cnt_load_val = 8'h00;
    cnt_out_e    = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          state_d = req_op ? LOAD : ENABLE;
        end
      end
      LOAD: begin
        cnt_load_e   = 1'b1;
        cnt_load_val = load_val_q;
        state_d      = IDLE;
      end
      ENABLE: begin
        cnt_out_e = 1'b1;
        if (sample) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_data = rsp_data_q;

`ifdef COUNTER_READER_DELTA_EN
  logic [7:0] ref_q;
  logic [7:0] rsp_delta_q;

  // Reference tracks the last value written to or read from the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q       <= 8'h00;
      rsp_delta_q <= 8'h00;
    end else if (accept && req_op) begin
      ref_q <= req_data;
    end else if (sample) begin
      ref_q       <= cnt_bus;
      rsp_delta_q <= cnt_bus - ref_q;
    end
  end

  assign rsp_delta = rsp_delta_q;
`else
  assign rsp_delta = 8'h00;
`endif

endmodule
